// File: rtl/d_mem_arbiter.sv
// Two-port arbiter sharing one d_mem: latch, one-cycle ACCESS, then a one-cycle ack.
// Define D_MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module d_mem_arbiter #(
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writeData,
   output logic        mem_memWrite,
   output logic        mem_memRead,
   input  logic [31:0] mem_readData
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e      state_q, state_d;
   logic        sel_q, sel_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        last_grant_q, last_grant_d;
   logic        mem_we_q, mem_we_d;
   logic        mem_re_q, mem_re_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        grant1;

   function automatic logic in_range(input logic [31:0] a);
      return {2'b00, a[31:2]} < MEM_DEPTH;
   endfunction

   always_comb begin
      if (req0 && req1) begin
`ifdef D_MEM_ARB_FIXED_PRIO_EN
         grant1 = 1'b0;
`else
         grant1 = ~last_grant_q;
`endif
      end else begin
         grant1 = req1;
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      last_grant_d = last_grant_q;
      mem_we_d     = 1'b0;
      mem_re_d     = 1'b0;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      err_d        = err_q;
      rdata_d      = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               sel_d        = grant1;
               we_d         = grant1 ? we1 : we0;
               addr_d       = grant1 ? addr1 : addr0;
               wdata_d      = grant1 ? wdata1 : wdata0;
               last_grant_d = grant1;
               // Strobes are registered so they are live for exactly the ACCESS cycle.
               mem_we_d     = we_d & in_range(addr_d);
               mem_re_d     = ~we_d & in_range(addr_d);
               state_d      = StAccess;
            end
         end
         StAccess: begin
            err_d = ~in_range(addr_q);
            if (!we_q) begin
               rdata_d = in_range(addr_q) ? mem_readData : 32'h0;
            end
            state_d = StResp;
         end
         StResp: begin
            // Acks are registered out of RESP, so they show in the following cycle.
            ack0_d  = ~sel_q;
            ack1_d  = sel_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         sel_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         last_grant_q <= 1'b1;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         last_grant_q <= last_grant_d;
         mem_we_q     <= mem_we_d;
         mem_re_q     <= mem_re_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
      end
   end

   assign ack0          = ack0_q;
   assign ack1          = ack1_q;
   assign err           = err_q;
   assign rdata         = rdata_q;
   assign mem_address   = addr_q;
   assign mem_writeData = wdata_q;
   assign mem_memWrite  = mem_we_q;
   assign mem_memRead   = mem_re_q;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Scoreboard bench for d_mem_arbiter with a behavioural d_mem; honours D_MEM_ARB_FIXED_PRIO_EN.
module tb_d_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1, err, mem_memWrite, mem_memRead;
   logic [31:0] rdata, mem_address, mem_writeData, mem_readData;

   int tests = 0;
   int fails = 0;
   int wr_cycles = 0;
   int rd_cycles = 0;

   typedef struct packed {
      logic        port;
      logic        err;
      logic        chk_rd;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic [31:0] mem [256];

   d_mem_arbiter #(.MEM_DEPTH(256)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
      .mem_address(mem_address), .mem_writeData(mem_writeData),
      .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
      .mem_readData(mem_readData)
   );

   always #5 clk = ~clk;

   assign mem_readData = ({2'b00, mem_address[31:2]} < 32'd256) ? mem[mem_address[9:2]] : 32'h0;

   always @(posedge clk) begin
      if (mem_memWrite) mem[mem_address[9:2]] <= mem_writeData;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_ack(input logic port, input logic e, input logic chk,
                             input logic [31:0] rd);
      sb.push_back('{port: port, err: e, chk_rd: chk, rdata: rd});
   endtask

   // Monitor: pops one expectation per ack seen on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_memWrite) wr_cycles++;
         if (mem_memRead) rd_cycles++;
         if (ack0 && ack1) begin
            tests++;
            fails++;
            $display("FAIL ack_both: ack0=%b ack1=%b required not both", ack0, ack1);
         end else if (ack0 || ack1) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ack: ack0=%b ack1=%b with no pending expectation",
                        ack0, ack1);
            end else begin
               mon_e = sb.pop_front();
               check("ack_port", {31'h0, ack1}, {31'h0, mon_e.port});
               check("ack_err", {31'h0, err}, {31'h0, mon_e.err});
               if (mon_e.chk_rd) check("ack_rdata", rdata, mon_e.rdata);
            end
         end
      end
   end

   task automatic issue(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat);
      @(negedge clk);
      if (port) begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
      end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if ((port && ack1) || (!port && ack0)) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) begin
         tests++;
         fails++;
         $display("FAIL ack_timeout: port %0d got no ack within 20 cycles", port);
      end
      if (port) req1 = 1'b0; else req0 = 1'b0;
   endtask

   initial begin
      int lat, lat_a, lat_b, wr0, rd0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0] = 32'h0000_1111;
      mem[2] = 32'h0000_2222;
      mem[5] = 32'hDEAD_BEEF;

      // Reset values.
      #12;
      check("rst_ack0", {31'h0, ack0}, 32'h0);
      check("rst_ack1", {31'h0, ack1}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_memWrite", {31'h0, mem_memWrite}, 32'h0);
      check("rst_memRead", {31'h0, mem_memRead}, 32'h0);
      check("rst_address", mem_address, 32'h0);
      check("rst_writeData", mem_writeData, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Single read on port 1.
      rd0 = rd_cycles;
      expect_ack(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
      issue(1'b1, 1'b0, 32'h14, 32'h0, lat);
      check("single_read_latency", 32'(lat), 32'd3);
      check("single_read_strobe", 32'(rd_cycles - rd0), 32'd1);

      // Four rounds of simultaneous requests after a port-1 grant.
      expect_ack(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      expect_ack(1'b1, 1'b0, 1'b1, 32'h0000_1111);
      expect_ack(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      expect_ack(1'b1, 1'b0, 1'b1, 32'h0000_1111);
      fork
         begin
            issue(1'b0, 1'b0, 32'h14, 32'h0, lat_a);
            issue(1'b0, 1'b0, 32'h14, 32'h0, lat_a);
         end
         begin
            issue(1'b1, 1'b0, 32'h0, 32'h0, lat_b);
            issue(1'b1, 1'b0, 32'h0, 32'h0, lat_b);
         end
      join

      // Write then read on port 0.
      wr0 = wr_cycles;
      expect_ack(1'b0, 1'b0, 1'b0, 32'h0);
      issue(1'b0, 1'b1, 32'h40, 32'h1234_5678, lat);
      check("write_strobe_cycles", 32'(wr_cycles - wr0), 32'd1);
      check("write_committed", mem[16], 32'h1234_5678);
      expect_ack(1'b0, 1'b0, 1'b1, 32'h1234_5678);
      issue(1'b0, 1'b0, 32'h40, 32'h0, lat);
      check("read_back_latency", 32'(lat), 32'd3);

      // Tie after a port-0 grant separates round-robin from fixed priority.
`ifdef D_MEM_ARB_FIXED_PRIO_EN
      expect_ack(1'b0, 1'b0, 1'b1, 32'h1234_5678);
      expect_ack(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
`else
      expect_ack(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
      expect_ack(1'b0, 1'b0, 1'b1, 32'h1234_5678);
`endif
      fork
         issue(1'b0, 1'b0, 32'h40, 32'h0, lat_a);
         issue(1'b1, 1'b0, 32'h14, 32'h0, lat_b);
      join
`ifdef D_MEM_ARB_FIXED_PRIO_EN
      check("tie_winner_latency", 32'(lat_a), 32'd3);
`else
      check("tie_winner_latency", 32'(lat_b), 32'd3);
`endif

      // Out-of-range write, then word 0 read, then out-of-range read.
      wr0 = wr_cycles;
      expect_ack(1'b0, 1'b1, 1'b0, 32'h0);
      issue(1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF, lat);
      check("oor_no_write_strobe", 32'(wr_cycles - wr0), 32'd0);
      check("oor_word0_intact", mem[0], 32'h0000_1111);
      expect_ack(1'b0, 1'b0, 1'b1, 32'h0000_1111);
      issue(1'b0, 1'b0, 32'h0, 32'h0, lat);
      rd0 = rd_cycles;
      expect_ack(1'b1, 1'b1, 1'b1, 32'h0);
      issue(1'b1, 1'b0, 32'h400, 32'h0, lat);
      check("oor_no_read_strobe", 32'(rd_cycles - rd0), 32'd0);

      // Reset asserted during the ACCESS cycle of a write.
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hAAAA_5555;
      @(posedge clk);
      #2;
      check("access_strobe_before_reset", {31'h0, mem_memWrite}, 32'h1);
      reset = 1'b1;
      #1;
      check("midrst_memWrite", {31'h0, mem_memWrite}, 32'h0);
      check("midrst_memRead", {31'h0, mem_memRead}, 32'h0);
      check("midrst_address", mem_address, 32'h0);
      check("midrst_writeData", mem_writeData, 32'h0);
      check("midrst_rdata", rdata, 32'h0);
      check("midrst_err", {31'h0, err}, 32'h0);
      req0 = 1'b0; we0 = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst_word2_intact", mem[2], 32'h0000_2222);

      // Back-to-back: req0 kept high one edge past its ack yields a second transaction.
      expect_ack(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      expect_ack(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h14;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ack0) begin
            lat = i;
            break;
         end
      end
      check("b2b_first_latency", 32'(lat), 32'd3);
      @(posedge clk);
      #1;
      req0 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ack0) begin
            lat = i;
            break;
         end
      end
      check("b2b_second_ack_gap", 32'(lat), 32'd3);

      repeat (8) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
